// File: rtl/cpu_pkg.sv
// Shared core types and constants: PC/instruction widths, fetch FSM states, opcode helper.
package cpu_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 21;
  localparam int OPC_W   = 5;

  localparam logic [OPC_W-1:0]   HALT_OPC  = 5'h1F;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_HALT
  } fetch_state_t;

  typedef logic [PC_W-1:0] pc_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones. 1-cycle update latency.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PC, drives 1-cycle sync imem, aligns data with its PC; 1 instr/cycle,
// first valid word 2 cycles after a PC load. stall_i holds all PC state; redirect squashes the shown word.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter pc_t RESET_PC = 12'h000,
  parameter int  CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               branch_taken_i,
  input  logic [PC_W-1:0]    branch_target_i,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [PC_W-1:0]    if_pc_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic               if_valid_o,
  output logic               halted_o,
  output logic [CNT_W-1:0]   fetch_cnt_o
);

  pc_t          pc_q;
  pc_t          pc_d1;
  fetch_state_t state;
  logic         accept;
  logic         is_halt;

  assign is_halt = (opcode_of(imem_rdata_i) == HALT_OPC);

  assign imem_addr_o = pc_q;
  assign if_pc_o     = pc_d1;
  assign if_valid_o  = (state == S_RUN) && !branch_taken_i;
  assign if_instr_o  = if_valid_o ? imem_rdata_i : NOP_INSTR;
  assign halted_o    = (state == S_HALT);
  assign accept      = if_valid_o && !stall_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      pc_d1 <= '0;
      state <= S_FILL;
    end else begin
      unique case (state)
        S_FILL: begin
          if (branch_taken_i) begin
            pc_q <= branch_target_i;
          end else begin
            pc_d1 <= pc_q;
            pc_q  <= pc_q + pc_t'(1);
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // Redirect outranks stall and HALT so a wrong-path HALT never stops fetch.
          if (branch_taken_i) begin
            pc_q  <= branch_target_i;
            state <= S_FILL;
          end else if (stall_i) begin
            state <= S_RUN;
          end else if (is_halt) begin
            state <= S_HALT;
          end else begin
            pc_d1 <= pc_q;
            pc_q  <= pc_q + pc_t'(1);
          end
        end
        S_HALT: begin
          if (branch_taken_i) begin
            pc_q  <= branch_target_i;
            state <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_fetch_cnt (
    .clk  (clk),
    .clr  (rst),
    .inc  (accept),
    .count(fetch_cnt_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a 1-cycle-latency ROM holding word[a] = {5'h01, 4'h0, a}.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic [11:0] imem_addr;
  logic [20:0] imem_rdata;
  logic [11:0] if_pc;
  logic [20:0] if_instr;
  logic        if_valid;
  logic        halted;
  logic [15:0] fetch_cnt;

  logic [20:0] rom [4096];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= rom[imem_addr];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .imem_addr_o    (imem_addr),
    .imem_rdata_i   (imem_rdata),
    .if_pc_o        (if_pc),
    .if_instr_o     (if_instr),
    .if_valid_o     (if_valid),
    .halted_o       (halted),
    .fetch_cnt_o    (fetch_cnt)
  );

  function automatic logic [20:0] word(input logic [11:0] a);
    return {5'h01, 4'h0, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic [11:0] pc);
    chk({tag, "_pc"},    32'(if_pc),    32'(pc));
    chk({tag, "_valid"}, 32'(if_valid), 32'h1);
    chk({tag, "_instr"}, 32'(if_instr), 32'(word(pc)));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = word(12'(i));
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // 1. reset and straight-line fetch
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_addr",   32'(imem_addr), 32'h0);
    chk("rst_pc",     32'(if_pc),     32'h0);
    chk("rst_valid",  32'(if_valid),  32'h0);
    chk("rst_instr",  32'(if_instr),  32'h0);
    chk("rst_halted", 32'(halted),    32'h0);
    chk("rst_cnt",    32'(fetch_cnt), 32'h0);
    tick(); chk_fetch("run0", 12'h000);
    tick(); chk_fetch("run1", 12'h001);
    tick(); chk_fetch("run2", 12'h002);
    tick(); chk("run_cnt3", 32'(fetch_cnt), 32'd3);

    // 2. stall for 3 cycles with pc 5 displayed
    tick(); tick();
    stall = 1'b1; #1;
    chk_fetch("stall_first", 12'h005);
    chk("stall_addr", 32'(imem_addr), 32'h6);
    chk("stall_cnt",  32'(fetch_cnt), 32'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc",    32'(if_pc),     32'h5);
      chk("stall_valid", 32'(if_valid),  32'h1);
      chk("stall_addr",  32'(imem_addr), 32'h6);
      chk("stall_cnt",   32'(fetch_cnt), 32'd5);
    end
    stall = 1'b0;
    tick(); chk_fetch("stall_release", 12'h006);
    chk("stall_release_cnt", 32'(fetch_cnt), 32'd6);

    // 3. redirect while stalled at pc 7
    tick();
    chk("br_pc7", 32'(if_pc), 32'h7);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 12'h100; #1;
    chk("br_squash_valid", 32'(if_valid), 32'h0);
    chk("br_squash_instr", 32'(if_instr), 32'h0);
    tick();
    stall = 1'b0; branch_taken = 1'b0; #1;
    chk("br_fill_valid", 32'(if_valid),  32'h0);
    chk("br_fill_addr",  32'(imem_addr), 32'h100);
    tick(); chk_fetch("br_target", 12'h100);
    chk("br_cnt", 32'(fetch_cnt), 32'd7);

    // 4. HALT at address 9
    rom[9] = {5'h1F, 4'h0, 12'h009};
    branch_taken = 1'b1; branch_target = 12'h008; #1;
    tick();
    branch_taken = 1'b0;
    tick(); chk_fetch("halt_pre8", 12'h008);
    tick();
    chk("halt_word_pc",    32'(if_pc),    32'h9);
    chk("halt_word_valid", 32'(if_valid), 32'h1);
    chk("halt_word_instr", 32'(if_instr), 32'({5'h1F, 4'h0, 12'h009}));
    chk("halt_word_cnt",   32'(fetch_cnt), 32'd8);
    tick();
    rom[9] = word(12'h009);
    chk("halt_cnt", 32'(fetch_cnt), 32'd9);
    for (int i = 0; i < 11; i++) begin
      chk("halt_halted", 32'(halted),    32'h1);
      chk("halt_valid",  32'(if_valid),  32'h0);
      chk("halt_hold",   32'(fetch_cnt), 32'd9);
      tick();
    end
    branch_taken = 1'b1; branch_target = 12'h020; #1;
    chk("unhalt_valid0", 32'(if_valid), 32'h0);
    tick();
    branch_taken = 1'b0; #1;
    chk("unhalt_halted", 32'(halted),   32'h0);
    chk("unhalt_valid1", 32'(if_valid), 32'h0);
    tick(); chk_fetch("unhalt_target", 12'h020);

    // 5. PC wrap
    branch_taken = 1'b1; branch_target = 12'hFFE; #1;
    tick();
    branch_taken = 1'b0;
    tick(); chk_fetch("wrap_ffe", 12'hFFE);
    tick(); chk_fetch("wrap_fff", 12'hFFF);
    tick(); chk_fetch("wrap_000", 12'h000);
    tick(); chk_fetch("wrap_001", 12'h001);

    // 6. reset wins over a simultaneous redirect
    branch_taken = 1'b1; branch_target = 12'h040; #1;
    tick();
    branch_taken = 1'b0;
    tick(); chk_fetch("pre_rst_40", 12'h040);
    rst = 1'b1; branch_taken = 1'b1; branch_target = 12'h123; #1;
    tick();
    rst = 1'b0; branch_taken = 1'b0; #1;
    chk("mrst_addr",   32'(imem_addr), 32'h0);
    chk("mrst_pc",     32'(if_pc),     32'h0);
    chk("mrst_valid",  32'(if_valid),  32'h0);
    chk("mrst_instr",  32'(if_instr),  32'h0);
    chk("mrst_halted", 32'(halted),    32'h0);
    chk("mrst_cnt",    32'(fetch_cnt), 32'h0);
    tick(); chk_fetch("mrst_restart", 12'h000);
    chk("mrst_next_addr", 32'(imem_addr), 32'h1);

    // 7. counter saturation after a long run
    for (int i = 0; i < 70000 && fetch_cnt != 16'hFFFE; i++) tick();
    chk("sat_reach_fffe", 32'(fetch_cnt), 32'hFFFE);
    tick(); chk("sat_ffff", 32'(fetch_cnt), 32'hFFFF);
    chk("sat_valid", 32'(if_valid), 32'h1);
    tick(); tick();
    chk("sat_hold", 32'(fetch_cnt), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
